// File: rtl/deck_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : deck_pkg                                                      |
// | Brief    : Shared constants, state encoding and card decode for the      |
// |            blackjack deck server.                                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package deck_pkg;

  // Deck geometry
  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;
  localparam int IDX_W     = 6;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (shift-left form)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Rank boundaries used by the point-value decode
  localparam int RANK_ACE  = 1;
  localparam int RANK_JACK = 11;
  localparam int RANK_KING = 13;

  // Blackjack point value of face cards
  localparam logic [3:0] FACE_POINTS = 4'd10;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SWAP  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FETCH = 3'd4,
    ST_HOLD  = 3'd5
  } deck_state_e;

  typedef struct packed {
    logic [3:0] value;
    logic       face;
    logic       ace;
  } card_t;

  // Card index 0..51 -> point value plus face/ace flags.
  // rank = (idx mod 13) + 1; ranks J..K (11..13) all score 10.
  function automatic card_t decode_card(input logic [IDX_W-1:0] idx);
    card_t      c;
    logic [3:0] rank;
    c    = '0;
    rank = 4'(idx % IDX_W'(RANKS)) + 4'd1;
    if (rank == 4'(RANK_ACE)) begin
      c.value = 4'd1;
      c.ace   = 1'b1;
    end else if (rank >= 4'(RANK_JACK) && rank <= 4'(RANK_KING)) begin
      c.value = FACE_POINTS;
      c.face  = 1'b1;
    end else begin
      c.value = rank;
    end
    return c;
  endfunction

endpackage : deck_pkg
`default_nettype wire

// File: rtl/deck_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : deck_lfsr                                                     |
// | Brief    : Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.         |
// |            Loads the seed on reset and advances on every clock.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module deck_lfsr
  import deck_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] seed_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       fb_d;

  // Feedback is the parity of the tapped bits, shifted in at the LSB
  always_comb begin
    fb_d   = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = {lfsr_q[6:0], fb_d};
  end

  // State register; seed must be nonzero or the sequence sticks at zero
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule : deck_lfsr
`default_nettype wire

// File: rtl/deck_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : deck_server                                                   |
// | Brief    : 52-card deck with LFSR-driven Fisher-Yates shuffle and a      |
// |            level-handshaked card fetch port returning blackjack points.  |
// |            Optional build macro DECK_NOSHUFFLE_EN: a shuffle request     |
// |            completes immediately and the deck stays in identity order.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module deck_server
  import deck_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Shuffler,
  input  logic             Sum,
  input  logic [IDX_W-1:0] i_Memory_Adress,
  output logic             Finish,
  output logic             Ok,
  output logic [3:0]       o_Card,
  output logic             o_Face,
  output logic             o_Ace
);

  deck_state_e      state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;        // INIT fill pointer
  logic [IDX_W-1:0] i_q, i_d;        // Fisher-Yates upper index
  logic [IDX_W-1:0] addr_q, addr_d;  // latched fetch address
  card_t            card_q, card_d;
  logic             swap_en_d;

  logic [IDX_W-1:0] deck_q [DECK_SIZE];

  logic [7:0]       lfsr_state;
  logic [IDX_W-1:0] swap_j;
  logic             unused_lfsr_hi;

  deck_lfsr u_lfsr (
    .Clock   (Clock),
    .Reset   (Reset),
    .seed_i  (SEED),
    .state_o (lfsr_state)
  );

  // Candidate swap partner comes from the low LFSR bits; the top bits only
  // contribute through the sequence itself.
  assign swap_j         = lfsr_state[IDX_W-1:0];
  assign unused_lfsr_hi = ^lfsr_state[7:IDX_W];

  // Next-state, counters and registered card decode
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    addr_d    = addr_q;
    card_d    = card_q;
    swap_en_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (k_q == IDX_W'(DECK_SIZE - 1)) begin
          k_d     = '0;
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // A shuffle request wins over a simultaneous fetch request
        if (Shuffler) begin
`ifdef DECK_NOSHUFFLE_EN
          state_d = ST_DONE;
`else
          i_d     = IDX_W'(DECK_SIZE - 1);
          state_d = ST_SWAP;
`endif
        end else if (Sum) begin
          addr_d  = i_Memory_Adress;
          state_d = ST_FETCH;
        end
      end
      ST_SWAP: begin
        // Out-of-range partner: retry next cycle with a fresh LFSR value
        if (swap_j <= i_q) begin
          swap_en_d = 1'b1;
          if (i_q == IDX_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            i_d = i_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!Shuffler) begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (addr_q < IDX_W'(DECK_SIZE)) begin
          card_d = decode_card(deck_q[addr_q]);
        end else begin
          card_d = '0;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!Sum) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control registers; reset restarts the deck fill from entry 0
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      k_q     <= '0;
      i_q     <= '0;
      addr_q  <= '0;
      card_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      addr_q  <= addr_d;
      card_q  <= card_d;
    end
  end

  // Deck storage: identity fill during INIT, single-cycle swap during SWAP
  always_ff @(posedge Clock) begin
    if (Reset) begin
      if (state_q == ST_INIT) begin
        deck_q[k_q] <= k_q;
      end else if (swap_en_d) begin
        deck_q[i_q]    <= deck_q[swap_j];
        deck_q[swap_j] <= deck_q[i_q];
      end
    end
  end

  // Status flags are decoded from distinct states, so they are exclusive
  assign Finish = (state_q == ST_DONE);
  assign Ok     = (state_q == ST_HOLD);
  assign o_Card = card_q.value;
  assign o_Face = card_q.face;
  assign o_Ace  = card_q.ace;

endmodule : deck_server
`default_nettype wire

// File: tb/tb_deck_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_deck_server                                                |
// | Brief    : Self-checking bench for deck_server: reset/init latency,      |
// |            card decode, out-of-range fetch, shuffle permutation          |
// |            properties, request priority and reset during a shuffle.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_deck_server;

  logic       clk;
  logic       rst_n;
  logic       shuffler;
  logic       sum;
  logic [5:0] addr;
  logic       finish;
  logic       ok;
  logic [3:0] card;
  logic       face;
  logic       ace;

  int n_checks;
  int n_pass;

  deck_server #(.SEED(8'hA5)) dut (
    .Clock           (clk),
    .Reset           (rst_n),
    .Shuffler        (shuffler),
    .Sum             (sum),
    .i_Memory_Adress (addr),
    .Finish          (finish),
    .Ok              (ok),
    .o_Card          (card),
    .o_Face          (face),
    .o_Ace           (ace)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: blackjack value of card index idx, packed {ace, face, points}
  function automatic logic [5:0] model_card(input int idx);
    int r;
    if (idx >= 52) return 6'd0;
    r = (idx % 13) + 1;
    if (r == 1)  return {1'b1, 1'b0, 4'd1};
    if (r > 10)  return {1'b0, 1'b1, 4'd10};
    return {1'b0, 1'b0, 4'(r)};
  endfunction

  // One full fetch handshake; returns {ace, face, points} seen while Ok=1
  task automatic do_fetch(input logic [5:0] a, input int hold, output logic [5:0] res);
    logic stable;
    sum  = 1'b1;
    addr = a;
    step();
    check_val("ok_early", {31'd0, ok}, 32'd0);
    addr = 6'($urandom_range(0, 63));  // address only matters when latched
    step();
    check_val("ok_lat", {31'd0, ok}, 32'd1);
    check_val("fin_in_fetch", {31'd0, finish}, 32'd0);
    res    = {ace, face, card};
    stable = 1'b1;
    for (int h = 1; h < hold; h++) begin
      step();
      if (!ok || ({ace, face, card} != res)) stable = 1'b0;
    end
    check_val("hold_stable", {31'd0, stable}, 32'd1);
    sum = 1'b0;
    step();
    check_val("ok_drop", {31'd0, ok}, 32'd0);
  endtask

  // Shuffle request; reports whether Finish was reached and Ok stayed low
  task automatic do_shuffle(input logic with_sum);
    int   cyc;
    logic ok_seen;
    logic fin_held;
    shuffler = 1'b1;
    sum      = with_sum;
    addr     = 6'($urandom_range(0, 51));
    cyc      = 0;
    ok_seen  = 1'b0;
    while (!finish && cyc < 5000) begin
      step();
      cyc++;
      if (ok) ok_seen = 1'b1;
    end
    check_val("shuf_done", {31'd0, finish}, 32'd1);
    fin_held = 1'b1;
    for (int e = 0; e < int'($urandom_range(0, 3)); e++) begin
      step();
      if (!finish) fin_held = 1'b0;
      if (ok) ok_seen = 1'b1;
    end
    check_val("fin_held", {31'd0, fin_held}, 32'd1);
    shuffler = 1'b0;
    sum      = 1'b0;
    step();
    check_val("fin_drop", {31'd0, finish}, 32'd0);
    if (ok) ok_seen = 1'b1;
    step();
    if (ok) ok_seen = 1'b1;
    check_val("ok_in_shuf", {31'd0, ok_seen}, 32'd0);
  endtask

  initial begin : main
    logic [5:0] got;
    logic       early_ok;
    int         cnt [11];
    int         n_face;
    int         n_ace;
    int         n_diff;
    int         ord [52];
    int         tmp;
    int         sel;

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    shuffler = 1'b0;
    sum      = 1'b0;
    addr     = 6'd0;

    // Reset held three cycles
    for (int c = 0; c < 3; c++) step();
    check_val("rst_finish", {31'd0, finish}, 32'd0);
    check_val("rst_ok", {31'd0, ok}, 32'd0);
    check_val("rst_card", {26'd0, ace, face, card}, 32'd0);

    // Fetch requested immediately: waits out INIT, IDLE at cycle 53
    rst_n    = 1'b1;
    sum      = 1'b1;
    addr     = 6'd0;
    early_ok = 1'b0;
    for (int c = 0; c < 53; c++) begin
      step();
      if (ok || finish) early_ok = 1'b1;
    end
    check_val("init_wait", {31'd0, early_ok}, 32'd0);
    step();
    check_val("first_ok", {31'd0, ok}, 32'd1);
    check_val("first_card", {26'd0, ace, face, card}, {26'd0, model_card(0)});
    sum = 1'b0;
    step();
    check_val("first_drop", {31'd0, ok}, 32'd0);

    // Directed decode corners on the identity deck
    do_fetch(6'd12, 2, got);
    check_val("card_k", {26'd0, got}, {26'd0, model_card(12)});
    do_fetch(6'd9, 1, got);
    check_val("card_10", {26'd0, got}, {26'd0, model_card(9)});
    do_fetch(6'd52, 3, got);
    check_val("card_oor", {26'd0, got}, 32'd0);

    // Random reads of the identity deck, including out-of-range addresses
    for (int n = 0; n < 24; n++) begin
      tmp = int'($urandom_range(0, 63));
      do_fetch(6'(tmp), int'($urandom_range(1, 4)), got);
      check_val("rand_read", {26'd0, got}, {26'd0, model_card(tmp)});
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end

    // Shuffle and fetch requested together: shuffle wins
    do_shuffle(1'b1);

    // Read all 52 positions in random order; check rank multiset
    for (int v = 0; v < 11; v++) cnt[v] = 0;
    n_face = 0;
    n_ace  = 0;
    n_diff = 0;
    for (int p = 0; p < 52; p++) ord[p] = p;
    for (int p = 51; p > 0; p--) begin
      sel      = int'($urandom_range(0, p));
      tmp      = ord[p];
      ord[p]   = ord[sel];
      ord[sel] = tmp;
    end
    for (int p = 0; p < 52; p++) begin
      do_fetch(6'(ord[p]), int'($urandom_range(1, 3)), got);
      cnt[got[3:0]]++;
      if (got[4]) n_face++;
      if (got[5]) n_ace++;
      if (got != model_card(ord[p])) n_diff++;
    end
    for (int v = 1; v <= 10; v++) begin
      check_val("rank_count", cnt[v], (v == 10) ? 32'd16 : 32'd4);
    end
    check_val("zero_count", cnt[0], 32'd0);
    check_val("face_count", n_face, 32'd12);
    check_val("ace_count", n_ace, 32'd4);
`ifdef DECK_NOSHUFFLE_EN
    check_val("deck_order", n_diff, 32'd0);
`else
    check_val("deck_moved", {31'd0, (n_diff != 0)}, 32'd1);
`endif
    do_fetch(6'd63, 1, got);
    check_val("oor_after", {26'd0, got}, 32'd0);

    // Reset in the middle of a shuffle; deck must be rebuilt in order
    do_fetch(6'd3, 1, got);
    shuffler = 1'b1;
    for (int c = 0; c < 5; c++) step();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check_val("mid_rst_finish", {31'd0, finish}, 32'd0);
    check_val("mid_rst_ok", {31'd0, ok}, 32'd0);
    check_val("mid_rst_card", {26'd0, ace, face, card}, 32'd0);
    shuffler = 1'b0;
    rst_n    = 1'b1;
    for (int c = 0; c < 52; c++) step();
    n_diff = 0;
    for (int p = 0; p < 52; p++) begin
      do_fetch(6'(p), 1, got);
      if (got != model_card(p)) n_diff++;
    end
    check_val("reinit_identity", n_diff, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_deck_server
`default_nettype wire

// File: doc/deck_server.md
DECK_SERVER -- requirements
Module: deck_server

Interface
REQ-001 SHALL have parameter SEED, default 8'hA5: LFSR reset value, nonzero.
REQ-002 SHALL have port Clock  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port Shuffler  in  1  shuffle request, level.
REQ-005 SHALL have port Sum  in  1  card fetch request, level.
REQ-006 SHALL have port i_Memory_Adress  in  6  deck position to read, 0..51 valid.
REQ-007 SHALL have port Finish  out  1  shuffle complete.
REQ-008 SHALL have port Ok  out  1  card data valid.
REQ-009 SHALL have port o_Card  out  4  blackjack point value, 0..10.
REQ-010 SHALL have port o_Face  out  1  card is J/Q/K.
REQ-011 SHALL have port o_Ace  out  1  card is Ace.

Function
REQ-012 SHALL hold a 52-entry x 6-bit deck register array of card indices 0..51; rank = (index mod 13)+1.
REQ-013 SHALL decode rank 1 -> o_Card=1, o_Ace=1; ranks 2..10 -> o_Card=rank; ranks 11..13 -> o_Card=10, o_Face=1.
REQ-014 SHALL implement states INIT, IDLE, SWAP, DONE, FETCH, HOLD.
REQ-015 INIT SHALL write deck[k]=k for k=0..51, one entry per cycle (52 cycles), then go to IDLE.
REQ-016 IDLE with Shuffler=1 SHALL set i=51 and go to SWAP; Shuffler has priority over a simultaneous Sum.
REQ-017 SWAP SHALL form j=lfsr[5:0]; if j<=i, swap deck[i] and deck[j] in one cycle and decrement i; if j>i, retry next cycle with same i.
REQ-018 SWAP SHALL go to DONE after the swap with i=1.
REQ-019 DONE SHALL drive Finish=1 while Shuffler=1 and go to IDLE in the cycle after Shuffler is sampled 0.
REQ-020 IDLE with Sum=1 and Shuffler=0 SHALL latch i_Memory_Adress and go to FETCH.
REQ-021 FETCH SHALL register the decoded card of the latched address and go to HOLD; Ok=1 two cycles after Sum is first sampled high.
REQ-022 HOLD SHALL keep Ok=1 and the card outputs stable while Sum=1, and go to IDLE in the cycle after Sum is sampled 0.
REQ-023 An address >=52 SHALL complete the handshake with o_Card=0, o_Face=0, o_Ace=0.
REQ-024 Shuffler or Sum asserted outside IDLE SHALL be ignored until IDLE is reached.
REQ-025 The 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle in all states, so user timing adds entropy.
REQ-026 Finish and Ok SHALL never be high in the same cycle.

Reset
REQ-027 Reset=0 at a clock edge SHALL force INIT with k=0, lfsr=SEED, and Finish=Ok=o_Card=o_Face=o_Ace=0, including in mid-shuffle or mid-fetch.
REQ-028 Requests during INIT SHALL wait; the first IDLE is 53 cycles after reset release.

Configuration
REQ-029 With macro DECK_NOSHUFFLE_EN defined, SWAP SHALL be skipped: Shuffler in IDLE goes directly to DONE, and the deck remains identity order.
REQ-030 Without DECK_NOSHUFFLE_EN, REQ-017/REQ-018 apply.

Structure
REQ-031 Package deck_pkg SHALL hold DECK_SIZE=52, RANKS=13, the state enum, the LFSR tap constant, and the face/ace rank constants.
REQ-032 The LFSR SHALL be sub-module deck_lfsr (Clock, Reset, seed, 8-bit state out).

Verification
REQ-033 Reset held 3 cycles -> Finish=Ok=0; after release, IDLE reached at cycle 53.
REQ-034 DECK_NOSHUFFLE_EN: address 0 -> o_Card=1, o_Ace=1; address 12 -> o_Card=10, o_Face=1; address 9 -> o_Card=10, o_Face=0; Ok at Sum+2 cycles in each case.
REQ-035 Shuffle then read addresses 0..51 -> every index 0..51 appears exactly once, with 4 of each rank.
REQ-036 Sum with address 52 -> Ok=1 with o_Card=0 and o_Face=o_Ace=0; Sum low -> Ok=0 the next cycle.
REQ-037 Shuffler and Sum high together in IDLE -> shuffle runs and Finish asserts; Ok stays 0 throughout.
REQ-038 Reset asserted mid-SWAP -> Finish=0, INIT reruns, and the deck is identity afterwards.
